param_strobe_decoder: RTL and testbench
=======================================

// Module: param_strobe_decoder
// PURPOSE
//   Parametrised, registered SEL_W-to-NUM_OUT one-hot decoder with enable and valid/ready input.
//   Each accepted select drives one output line high for PULSE_LEN clock cycles, then returns all lines to 0.
//   It is the next generation of the 3-to-8 enable decoder.
//   It sits between a command source and per-channel strobe/load inputs.
// PARAMETERS
//   SEL_W     3  select width in bits (>=1)
//   NUM_OUT   8  number of output lines; 2 <= NUM_OUT <= 2**SEL_W
//   PULSE_LEN 1  cycles each strobe is held high (>=1)
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous, active-low reset
//   enable    in   1        block enable; low = outputs cleared, no accepts
//   in_valid  in   1        in_sel valid
//   in_ready  out  1        block can accept (combinational)
//   in_sel    in   SEL_W    line index to strobe
//   out       out  NUM_OUT  registered one-hot strobe bus
//   out_valid out  1        high while a strobe pulse is being driven
//   busy      out  1        high in PULSE state
//   err       out  1        out-of-range select flag (only with DECODER_OOR_CHECK_EN, else tied 0)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; out=0, out_valid=0, busy=0, err=0, counter=0.
//   States: IDLE, PULSE. Counter width = $clog2(PULSE_LEN+1).
//   in_ready = enable & (state==IDLE | (state==PULSE & cnt==0)).
//   Accept = in_valid & in_ready. Latency is 1 cycle.
//     - On the clock after an accept: out = 1<<in_sel, out_valid=1, busy=1, cnt=PULSE_LEN-1, state=PULSE.
//   PULSE with cnt!=0: cnt decrements by 1. out is held.
//   PULSE with cnt==0 (last pulse cycle):
//     - if accept: reload with new select (back-to-back; no idle gap, no zero cycle between strobes).
//     - otherwise: next cycle out=0, out_valid=0, busy=0, state=IDLE.
//   PULSE_LEN=1: each strobe lasts exactly one cycle; a continuous accept stream gives one strobe per cycle.
//   enable low while IDLE: no accept. Outputs stay 0.
//   enable low while in PULSE: abort. The next cycle gives out=0, out_valid=0, busy=0, state=IDLE.
//     The counter is discarded. A strobe is never resumed.
//   in_valid while not in_ready: ignored. The source must hold in_valid/in_sel until in_ready.
//   out is at most one-hot at all times. It never changes except on a clock edge.
//   rst_n asserted mid-pulse: out clears immediately (async). A pulse never resumes after reset.
//   Out-of-range select (in_sel >= NUM_OUT, possible only when NUM_OUT < 2**SEL_W): see CONFIGURATION.
// CONFIGURATION
//   Macro DECODER_OOR_CHECK_EN:
//   defined:
//     - An out-of-range accept raises err for exactly 1 cycle (the cycle after accept).
//     - out stays 0, out_valid stays 0, state returns to/stays IDLE.
//     - A pulse in progress (last cycle) ends normally.
//   undefined:
//     - err is tied 0.
//     - An out-of-range accept enters PULSE normally with out=0 and out_valid=1 for PULSE_LEN cycles.
//       Timing is identical to an in-range select.
// TESTING
//   1 Reset: rst_n=0 with in_valid=1, enable=1 -> out=0, out_valid=0, busy=0, err=0. in_ready=1 after release.
//   2 Default params, enable=1, sweep in_sel 0..7 with one accept each
//     -> out = 8'h01, 02, 04, ... 80, each 1 cycle after accept, 1 cycle wide. enable=0 sweep -> out=0 throughout.
//   3 PULSE_LEN=3, accept sel=5, then accept sel=2 presented continuously
//     -> out=8'h20 for 3 cycles, then 8'h04 immediately with no zero cycle.
//     in_ready=0 in the first 2 pulse cycles.
//   4 PULSE_LEN=4, accept sel=1, drop enable on pulse cycle 2
//     -> out=0, busy=0 on the next cycle. Restore enable -> in_ready=1. Also assert rst_n=0 mid-pulse -> out=0 asynchronously.
//   5 NUM_OUT=6, SEL_W=3, accept sel=7
//     -> with DECODER_OOR_CHECK_EN: err=1 for 1 cycle, out=0, busy=0.
//     -> without: out=6'h00, out_valid=1 for PULSE_LEN cycles, err=0.
//   6 Random valid/ready/enable traffic with a scoreboard
//     -> out always zero or one-hot, and every accepted in-range sel produces exactly PULSE_LEN cycles of its bit unless aborted.

Source files
------------

// File: rtl/param_strobe_decoder.sv
// One-hot strobe decoder: an accepted select drives out[in_sel] for PULSE_LEN cycles; option macro DECODER_OOR_CHECK_EN.
// Latency: 1 cycle from accept to strobe; back-to-back strobes with no gap when re-accepted on the last pulse cycle.
// Backpressure: in_ready is low while a pulse has cycles left or enable is low; the source holds in_valid/in_sel.
module param_strobe_decoder #(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0] dec;
  logic               accept;

  // Selects >= NUM_OUT match no bit, so an unchecked out-of-range strobe is all zeros.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      dec[i] = (in_sel == SEL_W'(i));
    end
  end

  assign in_ready = enable & ((state_q == IDLE) | ((state_q == PULSE) & (cnt_q == '0)));
  assign accept   = in_valid & in_ready;

`ifdef DECODER_OOR_CHECK_EN
  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);
  logic oor;
  logic err_q, err_d;

  assign oor = ({1'b0, in_sel} >= NUM_OUT_L);
`else
  logic oor;
  logic err_d;

  assign oor = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    if (!enable) begin
      // Abort: a dropped enable discards any pulse in flight.
      state_d     = IDLE;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept && oor) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b1;
    end else if (accept) begin
      state_d     = PULSE;
      cnt_d       = CNT_LOAD;
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (state_q == PULSE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d     = IDLE;
        out_d       = '0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef DECODER_OOR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == PULSE);

endmodule

// File: tb/tb_param_strobe_decoder.sv
// Directed checks of param_strobe_decoder across four parameter sets plus a constrained random run.
module tb_param_strobe_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [2:0] in_sel;

  logic       a_rdy, a_ov, a_busy, a_err;
  logic [7:0] a_out;
  logic       b_rdy, b_ov, b_busy, b_err;
  logic [7:0] b_out;
  logic       c_rdy, c_ov, c_busy, c_err;
  logic [7:0] c_out;
  logic       d_rdy, d_ov, d_busy, d_err;
  logic [5:0] d_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_strobe_decoder #(.SEL_W(3), .NUM_OUT(8), .PULSE_LEN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(a_rdy),
    .in_sel(in_sel), .out(a_out), .out_valid(a_ov), .busy(a_busy), .err(a_err));
  param_strobe_decoder #(.SEL_W(3), .NUM_OUT(8), .PULSE_LEN(3)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(b_rdy),
    .in_sel(in_sel), .out(b_out), .out_valid(b_ov), .busy(b_busy), .err(b_err));
  param_strobe_decoder #(.SEL_W(3), .NUM_OUT(8), .PULSE_LEN(4)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(c_rdy),
    .in_sel(in_sel), .out(c_out), .out_valid(c_ov), .busy(c_busy), .err(c_err));
  param_strobe_decoder #(.SEL_W(3), .NUM_OUT(6), .PULSE_LEN(2)) u_d (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(d_rdy),
    .in_sel(in_sel), .out(d_out), .out_valid(d_ov), .busy(d_busy), .err(d_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    enable   = 1'b1;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Random-run reference state for the PULSE_LEN=3 instance.
  logic [7:0] m_out;
  logic       m_busy;
  int         m_rem;
  logic       exp_rdy;

  initial begin
    rst_n    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    // 1: reset with valid/enable asserted
    check("rst_a_out", a_out, 0);  check("rst_a_ov", a_ov, 0);
    check("rst_a_busy", a_busy, 0); check("rst_a_err", a_err, 0);
    check("rst_b_out", b_out, 0);  check("rst_b_ov", b_ov, 0);
    check("rst_b_busy", b_busy, 0); check("rst_b_err", b_err, 0);
    check("rst_c_out", c_out, 0);  check("rst_c_ov", c_ov, 0);
    check("rst_c_busy", c_busy, 0); check("rst_c_err", c_err, 0);
    check("rst_d_out", d_out, 0);  check("rst_d_ov", d_ov, 0);
    check("rst_d_busy", d_busy, 0); check("rst_d_err", d_err, 0);
    step();
    check("rst_hold_out", a_out, 0);
    rst_n = 1'b1;
    #1;
    check("rst_a_rdy", a_rdy, 1); check("rst_b_rdy", b_rdy, 1);
    check("rst_c_rdy", c_rdy, 1); check("rst_d_rdy", d_rdy, 1);

    // 2: PULSE_LEN=1 sweep, continuous stream, one strobe per cycle
    do_reset();
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      step();
      check("sweep_out", a_out, 32'h1 << s);
      check("sweep_ov", a_ov, 1);
    end
    in_valid = 1'b0;
    step();
    check("sweep_end_out", a_out, 0);
    check("sweep_end_busy", a_busy, 0);
    // isolated accepts: 1 cycle wide
    for (int s = 0; s < 8; s += 3) begin
      in_sel   = 3'(s);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("single_out", a_out, 32'h1 << s);
      step();
      check("single_gap", a_out, 0);
    end
    // enable low sweep
    enable   = 1'b0;
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check("dis_rdy", a_rdy, 0);
      step();
      check("dis_out", a_out, 0);
      check("dis_ov", a_ov, 0);
    end

    // 3: PULSE_LEN=3 back-to-back
    do_reset();
    in_sel   = 3'd5;
    in_valid = 1'b1;
    step();
    check("b2b_c1_out", b_out, 8'h20);
    in_sel = 3'd2;
    #1;
    check("b2b_c1_rdy", b_rdy, 0);
    step();
    check("b2b_c2_out", b_out, 8'h20);
    check("b2b_c2_rdy", b_rdy, 0);
    step();
    check("b2b_c3_out", b_out, 8'h20);
    check("b2b_c3_rdy", b_rdy, 1);
    step();
    check("b2b_n1_out", b_out, 8'h04);
    in_valid = 1'b0;
    step();
    check("b2b_n2_out", b_out, 8'h04);
    step();
    check("b2b_n3_out", b_out, 8'h04);
    step();
    check("b2b_end_out", b_out, 0);
    check("b2b_end_busy", b_busy, 0);

    // 4: PULSE_LEN=4 abort via enable, then async reset mid-pulse
    do_reset();
    in_sel   = 3'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("abt_c1_out", c_out, 8'h02);
    step();
    check("abt_c2_out", c_out, 8'h02);
    enable = 1'b0;
    #1;
    check("abt_rdy_low", c_rdy, 0);
    step();
    check("abt_out", c_out, 0);
    check("abt_busy", c_busy, 0);
    check("abt_ov", c_ov, 0);
    enable = 1'b1;
    #1;
    check("abt_rdy_back", c_rdy, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("arst_pre_out", c_out, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", c_out, 0);
    check("arst_busy", c_busy, 0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_noresume_out", c_out, 0);
    check("arst_noresume_ov", c_ov, 0);

    // 5: NUM_OUT=6, PULSE_LEN=2, out-of-range select 7
    do_reset();
    in_sel   = 3'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef DECODER_OOR_CHECK_EN
    check("oor_err", d_err, 1);
    check("oor_out", d_out, 0);
    check("oor_busy", d_busy, 0);
    check("oor_ov", d_ov, 0);
    step();
    check("oor_err_clr", d_err, 0);
    check("oor_busy2", d_busy, 0);
`else
    check("oor_err", d_err, 0);
    check("oor_out", d_out, 0);
    check("oor_ov1", d_ov, 1);
    check("oor_busy1", d_busy, 1);
    step();
    check("oor_ov2", d_ov, 1);
    check("oor_out2", d_out, 0);
    step();
    check("oor_ov3", d_ov, 0);
    check("oor_busy3", d_busy, 0);
`endif
    in_sel   = 3'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("d_in_out1", d_out, 6'h20);
    step();
    check("d_in_out2", d_out, 6'h20);
    step();
    check("d_in_out3", d_out, 0);

    // 6: random traffic on PULSE_LEN=3 against a reference
    do_reset();
    m_out  = '0;
    m_busy = 1'b0;
    m_rem  = 0;
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (!(in_valid && !exp_rdy) || n == 0) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 3'($urandom_range(0, 7));
      end
      exp_rdy = enable && (!m_busy || m_rem == 0);
      #1;
      check("rnd_rdy", b_rdy, exp_rdy);
      if (!enable) begin
        m_out = '0; m_busy = 1'b0; m_rem = 0;
      end else if (in_valid && exp_rdy) begin
        m_out = 8'h1 << in_sel; m_busy = 1'b1; m_rem = 2;
      end else if (m_busy) begin
        if (m_rem > 0) m_rem--;
        else begin
          m_out = '0; m_busy = 1'b0;
        end
      end
      step();
      check("rnd_out", b_out, m_out);
      check("rnd_ov", b_ov, m_busy);
      check("rnd_busy", b_busy, m_busy);
      check("rnd_onehot", $onehot0(b_out), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
